// File: rtl/param_up_dn_counter.sv
// Bounded up/down counter with load, saturate-or-wrap behaviour and runtime limits.
// Counter and the Wrapped/Sat pulses are registered; High/Low/Err decode combinationally.
module param_up_dn_counter #(
    parameter int WIDTH  = 5,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LOAD,
    input  logic [WIDTH-1:0]  IN,
    input  logic              Up,
    input  logic              Down,
    input  logic              Enable,
    input  logic [STEP_W-1:0] Step,
    input  logic [WIDTH-1:0]  Min_Lim,
    input  logic [WIDTH-1:0]  Max_Lim,
    input  logic              Wrap,
    output logic [WIDTH-1:0]  Counter,
    output logic              High,
    output logic              Low,
    output logic              Wrapped,
    output logic              Sat,
    output logic              Err
);

    // One extra bit over the widest operand so sums and range never overflow.
    localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

    logic [WIDTH-1:0] r_counter;
    logic             r_wrapped;
    logic             r_sat;

    logic [EW-1:0]    w_min;
    logic [EW-1:0]    w_max;
    logic [EW-1:0]    w_cnt;
    logic [EW-1:0]    w_range;
    logic [EW-1:0]    w_estep;
    logic [EW-1:0]    w_sum;
    logic [EW-1:0]    w_floor;
    logic [WIDTH-1:0] w_nextCount;
    logic             w_wrapEv;
    logic             w_satEv;

    assign w_min   = EW'(Min_Lim);
    assign w_max   = EW'(Max_Lim);
    assign w_cnt   = EW'(r_counter);
    assign w_range = w_max - w_min + EW'(1);
    assign w_estep = (EW'(Step) > w_range) ? w_range : EW'(Step);
    assign w_sum   = w_cnt + w_estep;
    assign w_floor = w_min + w_estep;

    assign Err     = (Min_Lim > Max_Lim);
    assign High    = (r_counter == Max_Lim);
    assign Low     = (r_counter == Min_Lim);
    assign Counter = r_counter;
    assign Wrapped = r_wrapped;
    assign Sat     = r_sat;

    // Priority: error hold, load, realign, down, up; a zero step falls through as hold.
    always_comb begin
        w_nextCount = r_counter;
        w_wrapEv    = 1'b0;
        w_satEv     = 1'b0;
        if (!Err) begin
            if (LOAD) begin
                if (IN < Min_Lim) begin
                    w_nextCount = Min_Lim;
                    w_satEv     = 1'b1;
                end else if (IN > Max_Lim) begin
                    w_nextCount = Max_Lim;
                    w_satEv     = 1'b1;
                end else begin
                    w_nextCount = IN;
                end
            end else if (r_counter > Max_Lim) begin
                w_nextCount = Max_Lim;
                w_satEv     = 1'b1;
            end else if (r_counter < Min_Lim) begin
                w_nextCount = Min_Lim;
                w_satEv     = 1'b1;
            end else if (Enable && Down) begin
                if (w_cnt >= w_floor) begin
                    w_nextCount = WIDTH'(w_cnt - w_estep);
                end else if (Wrap) begin
                    w_nextCount = WIDTH'(w_max - (w_floor - w_cnt - EW'(1)));
                    w_wrapEv    = 1'b1;
                end else begin
                    w_nextCount = Min_Lim;
                    w_satEv     = 1'b1;
                end
            end else if (Enable && Up) begin
                if (w_sum <= w_max) begin
                    w_nextCount = WIDTH'(w_sum);
                end else if (Wrap) begin
                    w_nextCount = WIDTH'(w_min + (w_sum - w_max - EW'(1)));
                    w_wrapEv    = 1'b1;
                end else begin
                    w_nextCount = Max_Lim;
                    w_satEv     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_counter <= '0;
            r_wrapped <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_counter <= w_nextCount;
            r_wrapped <= w_wrapEv;
            r_sat     <= w_satEv;
        end
    end

endmodule

// File: tb/tb_param_up_dn_counter.sv
// Scoreboard bench for param_up_dn_counter: stimulus pushes model predictions,
// a monitor pops one per rising edge and compares the registered outputs.
module tb_param_up_dn_counter;

    typedef struct {
        int count;
        bit wrapped;
        bit sat;
        bit high;
        bit low;
        bit err;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       LOAD;
    logic [4:0] IN;
    logic       Up;
    logic       Down;
    logic       Enable;
    logic [2:0] Step;
    logic [4:0] Min_Lim;
    logic [4:0] Max_Lim;
    logic       Wrap;
    logic [4:0] Counter;
    logic       High;
    logic       Low;
    logic       Wrapped;
    logic       Sat;
    logic       Err;

    int         checks   = 0;
    int         failures = 0;
    int         mCount   = 0;
    expect_t    expQ[$];

    param_up_dn_counter #(.WIDTH(5), .STEP_W(3)) dut (
        .clk(clk), .rst(rst), .LOAD(LOAD), .IN(IN), .Up(Up), .Down(Down),
        .Enable(Enable), .Step(Step), .Min_Lim(Min_Lim), .Max_Lim(Max_Lim),
        .Wrap(Wrap), .Counter(Counter), .High(High), .Low(Low),
        .Wrapped(Wrapped), .Sat(Sat), .Err(Err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: counter as a plain integer, wrapping done as modular arithmetic over the range.
    task automatic modelStep(input int ld, input int inv, input int up, input int dn, input int en,
                             input int st, input int mn, input int mx, input int wr,
                             output int wrapEv, output int satEv);
        int rng;
        int e;
        int raw;
        wrapEv = 0;
        satEv  = 0;
        if (mn > mx) return;
        rng = mx - mn + 1;
        if (ld != 0) begin
            if (inv < mn) begin mCount = mn; satEv = 1; end
            else if (inv > mx) begin mCount = mx; satEv = 1; end
            else mCount = inv;
        end else if (mCount > mx || mCount < mn) begin
            mCount = (mCount > mx) ? mx : mn;
            satEv  = 1;
        end else if (en != 0 && (up != 0 || dn != 0) && st > 0) begin
            e   = (st < rng) ? st : rng;
            raw = (dn != 0) ? mCount - e : mCount + e;
            if (raw >= mn && raw <= mx) mCount = raw;
            else if (wr != 0) begin
                mCount = mn + (((raw - mn) % rng) + rng) % rng;
                wrapEv = 1;
            end else begin
                mCount = (dn != 0) ? mn : mx;
                satEv  = 1;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, predict the next edge, wait for the following falling edge.
    task automatic applyStimulus(input logic ld, input logic [4:0] inv, input logic up, input logic dn,
                                 input logic en, input logic [2:0] st, input logic [4:0] mn,
                                 input logic [4:0] mx, input logic wr);
        expect_t x;
        int      we;
        int      se;
        LOAD = ld; IN = inv; Up = up; Down = dn; Enable = en; Step = st;
        Min_Lim = mn; Max_Lim = mx; Wrap = wr;
        modelStep(int'(ld), int'(inv), int'(up), int'(dn), int'(en), int'(st),
                  int'(mn), int'(mx), int'(wr), we, se);
        x.count   = mCount;
        x.wrapped = (we != 0);
        x.sat     = (se != 0);
        x.high    = (mCount == int'(mx));
        x.low     = (mCount == int'(mn));
        x.err     = (mn > mx);
        expQ.push_back(x);
        @(negedge clk);
    endtask

    // Reset asserted between edges and held across one edge with stepping requested.
    task automatic pulseReset();
        LOAD = 1'b0; Up = 1'b1; Down = 1'b0; Enable = 1'b1; Step = 3'd3;
        Min_Lim = 5'd0; Max_Lim = 5'd31; Wrap = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("async_reset_counter", int'(Counter), 0);
        checkOutput("async_reset_low", int'(Low), 1);
        checkOutput("async_reset_sat", int'(Sat), 0);
        @(posedge clk);
        #1;
        checkOutput("reset_held_counter", int'(Counter), 0);
        checkOutput("reset_held_wrapped", int'(Wrapped), 0);
        @(negedge clk);
        rst = 1'b0;
        Enable = 1'b0;
        mCount = 0;
    endtask

    // Monitor: after every rising edge pop a prediction (if any) and compare all outputs.
    initial begin
        expect_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput("sb_counter", int'(Counter), x.count);
                checkOutput("sb_wrapped", int'(Wrapped), int'(x.wrapped));
                checkOutput("sb_sat", int'(Sat), int'(x.sat));
                checkOutput("sb_high", int'(High), int'(x.high));
                checkOutput("sb_low", int'(Low), int'(x.low));
                checkOutput("sb_err", int'(Err), int'(x.err));
            end
        end
    end

    // Main sequence: power-on reset, directed scenarios, mid-run reset, randomized traffic.
    initial begin
        logic [4:0] mn;
        logic [4:0] mx;
        rst = 1'b1; LOAD = 1'b0; IN = '0; Up = 1'b0; Down = 1'b0; Enable = 1'b0;
        Step = '0; Min_Lim = 5'd0; Max_Lim = 5'd31; Wrap = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("por_counter", int'(Counter), 0);
        checkOutput("por_low", int'(Low), 1);
        checkOutput("por_wrapped", int'(Wrapped), 0);
        rst = 1'b0;
        mCount = 0;

        applyStimulus(1, 5'd10, 1, 1, 1, 3'd2, 5'd0, 5'd31, 0);
        checkOutput("load_priority", int'(Counter), 10);
        applyStimulus(1, 5'd28, 0, 0, 1, 3'd2, 5'd0, 5'd20, 0);
        checkOutput("load_clamp_value", int'(Counter), 20);
        checkOutput("load_clamp_sat", int'(Sat), 1);

        applyStimulus(1, 5'd10, 0, 0, 0, 3'd4, 5'd0, 5'd31, 0);
        applyStimulus(0, 5'd0, 0, 1, 1, 3'd4, 5'd0, 5'd31, 0);
        checkOutput("satdown_1", int'(Counter), 6);
        applyStimulus(0, 5'd0, 0, 1, 1, 3'd4, 5'd0, 5'd31, 0);
        checkOutput("satdown_2", int'(Counter), 2);
        checkOutput("satdown_2_sat", int'(Sat), 0);
        applyStimulus(0, 5'd0, 0, 1, 1, 3'd4, 5'd0, 5'd31, 0);
        checkOutput("satdown_3", int'(Counter), 0);
        checkOutput("satdown_3_sat", int'(Sat), 1);
        checkOutput("satdown_3_low", int'(Low), 1);

        applyStimulus(1, 5'd18, 0, 0, 0, 3'd3, 5'd5, 5'd20, 1);
        applyStimulus(0, 5'd0, 1, 0, 1, 3'd3, 5'd5, 5'd20, 1);
        checkOutput("wrapup_1", int'(Counter), 5);
        checkOutput("wrapup_1_wrapped", int'(Wrapped), 1);
        applyStimulus(0, 5'd0, 1, 0, 1, 3'd3, 5'd5, 5'd20, 1);
        checkOutput("wrapup_2", int'(Counter), 8);
        checkOutput("wrapup_2_wrapped", int'(Wrapped), 0);

        applyStimulus(1, 5'd25, 0, 0, 0, 3'd1, 5'd0, 5'd31, 0);
        applyStimulus(0, 5'd0, 0, 0, 1, 3'd1, 5'd0, 5'd15, 0);
        checkOutput("realign_value", int'(Counter), 15);
        checkOutput("realign_high", int'(High), 1);
        checkOutput("realign_sat", int'(Sat), 1);

        applyStimulus(1, 5'd3, 1, 1, 1, 3'd2, 5'd20, 5'd10, 0);
        checkOutput("err_flag", int'(Err), 1);
        checkOutput("err_hold", int'(Counter), 15);
        applyStimulus(0, 5'd0, 1, 0, 0, 3'd2, 5'd0, 5'd31, 0);
        checkOutput("enable_gate", int'(Counter), 15);

        applyStimulus(0, 5'd0, 0, 0, 0, 3'd5, 5'd7, 5'd7, 1);
        checkOutput("equal_realign", int'(Counter), 7);
        applyStimulus(0, 5'd0, 1, 0, 1, 3'd5, 5'd7, 5'd7, 1);
        checkOutput("equal_wrap_pulse", int'(Wrapped), 1);
        checkOutput("equal_high_low", int'(High & Low), 1);

        pulseReset();

        mn = 5'd0;
        mx = 5'd31;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mn = 5'($urandom_range(0, 31));
                mx = 5'($urandom_range(0, 31));
                if (mn > mx && $urandom_range(0, 3) != 0) begin
                    logic [4:0] t;
                    t = mn; mn = mx; mx = t;
                end
            end
            if (i == 200) pulseReset();
            applyStimulus(($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)),
                          1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0),
                          3'($urandom), (i == 200) ? 5'd0 : mn, (i == 200) ? 5'd31 : mx,
                          1'($urandom));
        end

        @(posedge clk);
        #2;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
